memory_accessor: RTL and testbench
==================================

// Module: memory_accessor
// PURPOSE
//  Memory-access stage of the little-cpu pipeline, downstream of the executor.
//  Takes the executor result (rd, rd_data, mem_addr, mem_data, load/store flags).
//  Performs loads/stores on a single-outstanding valid/ready data bus.
//  Aligns store data, extracts and extends load data, then hands rd/rd_data to writeback.
// PARAMETERS
//  none (XLEN fixed at 32)
// PORTS
//  clk            in   1   clock; all state changes on posedge
//  reset          in   1   synchronous, active-high
//  in_valid       in   1   executor result valid
//  in_ready       out  1   stage can accept a result this cycle
//  in_rd          in   5   destination register
//  in_rd_data     in   32  ALU result; passed through for non-load ops
//  in_mem_addr    in   32  byte address for load/store
//  in_mem_data    in   32  store data, right-aligned
//  in_is_lb/lbu/lh/lhu/lw  in  1 each  load type
//  in_is_sb/sh/sw          in  1 each  store type
//  mem_valid      out  1   bus request
//  mem_ready      in   1   bus completes request this cycle
//  mem_addr       out  32  word address {addr[31:2],2'b00}
//  mem_wdata      out  32  lane-aligned store data
//  mem_wstrb      out  4   byte write strobes; 4'b0000 = read
//  mem_rdata      in   32  read data, valid when mem_valid&&mem_ready
//  out_valid      out  1   writeback result valid
//  out_ready      in   1   writeback accepts result
//  out_rd         out  5   destination register (0 for stores/faults)
//  out_rd_data    out  32  writeback value
//  out_misaligned out  1   access faulted on alignment; no bus cycle issued
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 except in_ready, which is 1 after reset.
//  in_ready = (state==IDLE) && (!out_valid || out_ready); transfer = in_valid && in_ready.
//  States: IDLE, BUS.
//  IDLE, transfer, no mem flag: out_rd/out_rd_data <= in_rd/in_rd_data; out_valid=1 next cycle (latency 1).
//  IDLE, transfer, mem op aligned: latch op; mem_valid=1 from next cycle; go to BUS.
//  Alignment rule: h ops need addr[0]==0; w ops need addr[1:0]==0; b ops are always aligned.
//  IDLE, transfer, misaligned: no bus request; out_valid=1, out_misaligned=1, out_rd=0, out_rd_data=0.
//  BUS: mem_valid, mem_addr, mem_wdata and mem_wstrb are held stable until mem_ready.
//  BUS, edge with mem_ready=1: mem_valid drops; out_valid=1 from that edge; return to IDLE.
//   Minimum load/store latency is therefore 2 cycles.
//  Store lanes, o=addr[1:0]:
//   sb: wdata={4{data[7:0]}}, wstrb=4'b0001<<o
//   sh: wdata={2{data[15:0]}}, wstrb=4'b0011<<o
//   sw: wdata=data, wstrb=4'b1111
//   Stores complete with out_rd=0.
//  Loads: byte=rdata>>(8*o). lb/lh sign-extend; lbu/lhu zero-extend; lw uses rdata as is.
//   Loads complete with out_rd=in_rd, including rd=0.
//  Multiple flags set (illegal input): priority lw>lh>lhu>lb>lbu>sw>sh>sb.
//  Output hold: out_* stay stable while out_valid && !out_ready.
//   out_valid drops after the edge where out_ready=1, unless a new result loads that edge.
//  out_ready=1 with in_valid=1 in IDLE: back-to-back ALU results, one per cycle, no bubble.
//  in_ready=0 throughout BUS; upstream must hold its inputs stable.
//  Reset mid-BUS: mem_valid=0 on the next cycle; the pending result is discarded, never emitted.
// TESTING
//  ALU op rd=5 rd_data=0x1234 out_ready=1 -> out_valid next cycle, out_rd=5, out_rd_data=0x1234
//  lb addr=0x1003, mem_ready at once, rdata=0x80112233 -> mem_addr=0x1000 wstrb=0, out_rd_data=0xFFFFFF80
//  sh addr=0x102 data=0xABCD1234 -> mem_wdata=0x12341234 wstrb=4'b1100, out_rd=0
//  lw addr=0x101 -> mem_valid stays 0; out_misaligned=1 after 1 cycle
//  lhu addr=0x2, mem_ready delayed 3 cycles -> mem_* stable 3 cycles; rdata=0x8001xxxx gives 0x00008001
//  reset asserted in BUS; out_ready=0 with out_valid=1 -> mem_valid=0 and no out_valid; in_ready=0, out_* held

Source files
------------

// File: rtl/memory_accessor.sv
// memory_accessor: memory-access stage of the little-cpu pipeline.
// Takes one executor result at a time. ALU results pass straight through to
// writeback with one cycle of latency. Aligned loads and stores go out on a
// valid/ready data bus that allows only one outstanding request. Misaligned
// accesses fault without any bus cycle.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   in_valid/in_ready          executor handshake
//   in_rd, in_rd_data          destination register and ALU result
//   in_mem_addr, in_mem_data   byte address and right-aligned store data
//   in_is_lb/lbu/lh/lhu/lw     load type flags
//   in_is_sb/sh/sw             store type flags
//   mem_valid/mem_ready        data bus handshake
//   mem_addr                   word-aligned bus address
//   mem_wdata, mem_wstrb       lane-aligned store data and byte strobes (0 = read)
//   mem_rdata                  read data, sampled when mem_valid && mem_ready
//   out_valid/out_ready        writeback handshake
//   out_rd, out_rd_data        writeback destination and value
//   out_misaligned             the access faulted on alignment
module memory_accessor (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rd_data,
  input  logic [31:0] in_mem_addr,
  input  logic [31:0] in_mem_data,
  input  logic        in_is_lb,
  input  logic        in_is_lbu,
  input  logic        in_is_lh,
  input  logic        in_is_lhu,
  input  logic        in_is_lw,
  input  logic        in_is_sb,
  input  logic        in_is_sh,
  input  logic        in_is_sw,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_rd_data,
  output logic        out_misaligned
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUS = 1'b1} state_t;

  // Operation codes; loads occupy 0..4 so a single compare identifies them.
  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   store_data = {4{d[7:0]}};
      OP_SH:   store_data = {2{d[15:0]}};
      OP_SW:   store_data = d;
      default: store_data = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_SB:   store_strb = 4'b0001 << off;
      OP_SH:   store_strb = 4'b0011 << off;
      OP_SW:   store_strb = 4'b1111;
      default: store_strb = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] op, input logic [31:0] rdata,
                                             input logic [1:0] off);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (op)
      OP_LB:   load_value = {{24{sh[7]}}, sh[7:0]};
      OP_LBU:  load_value = {24'h00_0000, sh[7:0]};
      OP_LH:   load_value = {{16{sh[15]}}, sh[15:0]};
      OP_LHU:  load_value = {16'h0000, sh[15:0]};
      OP_LW:   load_value = rdata;
      default: load_value = 32'h0000_0000;
    endcase
  endfunction

  state_t      state_r, state_next_s;
  logic [2:0]  op_r, op_next_s;
  logic [1:0]  off_r, off_next_s;
  logic [4:0]  rd_r, rd_next_s;
  logic        mem_valid_r, mem_valid_next_s;
  logic [31:0] mem_addr_r, mem_addr_next_s;
  logic [31:0] mem_wdata_r, mem_wdata_next_s;
  logic [3:0]  mem_wstrb_r, mem_wstrb_next_s;
  logic        out_valid_r, out_valid_next_s;
  logic [4:0]  out_rd_r, out_rd_next_s;
  logic [31:0] out_rd_data_r, out_rd_data_next_s;
  logic        out_mis_r, out_mis_next_s;

  logic [2:0]  op_s;
  logic        mem_op_s;
  logic        misalign_s;
  logic        in_ready_s;
  logic        transfer_s;

  // Decode load/store flags with fixed priority lw>lh>lhu>lb>lbu>sw>sh>sb.
  always_comb begin
    op_s     = OP_LW;
    mem_op_s = 1'b1;
    if (in_is_lw)       op_s = OP_LW;
    else if (in_is_lh)  op_s = OP_LH;
    else if (in_is_lhu) op_s = OP_LHU;
    else if (in_is_lb)  op_s = OP_LB;
    else if (in_is_lbu) op_s = OP_LBU;
    else if (in_is_sw)  op_s = OP_SW;
    else if (in_is_sh)  op_s = OP_SH;
    else if (in_is_sb)  op_s = OP_SB;
    else begin
      op_s     = OP_LW;
      mem_op_s = 1'b0;
    end
  end

  // Alignment check: words need addr[1:0]==0, halves need addr[0]==0.
  always_comb begin
    case (op_s)
      OP_LW, OP_SW:         misalign_s = mem_op_s && (in_mem_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misalign_s = mem_op_s && in_mem_addr[0];
      default:              misalign_s = 1'b0;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      op_r          <= OP_LW;
      off_r         <= 2'b00;
      rd_r          <= 5'd0;
      mem_valid_r   <= 1'b0;
      mem_addr_r    <= 32'h0000_0000;
      mem_wdata_r   <= 32'h0000_0000;
      mem_wstrb_r   <= 4'b0000;
      out_valid_r   <= 1'b0;
      out_rd_r      <= 5'd0;
      out_rd_data_r <= 32'h0000_0000;
      out_mis_r     <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      op_r          <= op_next_s;
      off_r         <= off_next_s;
      rd_r          <= rd_next_s;
      mem_valid_r   <= mem_valid_next_s;
      mem_addr_r    <= mem_addr_next_s;
      mem_wdata_r   <= mem_wdata_next_s;
      mem_wstrb_r   <= mem_wstrb_next_s;
      out_valid_r   <= out_valid_next_s;
      out_rd_r      <= out_rd_next_s;
      out_rd_data_r <= out_rd_data_next_s;
      out_mis_r     <= out_mis_next_s;
    end
  end

  // Next-state logic: only an aligned memory op enters BUS; mem_ready leaves it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (transfer_s && mem_op_s && !misalign_s) state_next_s = ST_BUS;
        else                                       state_next_s = ST_IDLE;
      end
      ST_BUS: begin
        if (mem_ready) state_next_s = ST_IDLE;
        else           state_next_s = ST_BUS;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output logic: handshake and next values of the bus/writeback registers.
  always_comb begin
    in_ready_s         = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    transfer_s         = in_valid && in_ready_s;
    op_next_s          = op_r;
    off_next_s         = off_r;
    rd_next_s          = rd_r;
    mem_valid_next_s   = mem_valid_r;
    mem_addr_next_s    = mem_addr_r;
    mem_wdata_next_s   = mem_wdata_r;
    mem_wstrb_next_s   = mem_wstrb_r;
    out_valid_next_s   = out_valid_r;
    out_rd_next_s      = out_rd_r;
    out_rd_data_next_s = out_rd_data_r;
    out_mis_next_s     = out_mis_r;
    case (state_r)
      ST_IDLE: begin
        if (transfer_s) begin
          if (!mem_op_s) begin
            out_valid_next_s   = 1'b1;
            out_rd_next_s      = in_rd;
            out_rd_data_next_s = in_rd_data;
            out_mis_next_s     = 1'b0;
          end else if (misalign_s) begin
            out_valid_next_s   = 1'b1;
            out_rd_next_s      = 5'd0;
            out_rd_data_next_s = 32'h0000_0000;
            out_mis_next_s     = 1'b1;
          end else begin
            // Any previous result was consumed on this same edge.
            out_valid_next_s = 1'b0;
            op_next_s        = op_s;
            off_next_s       = in_mem_addr[1:0];
            rd_next_s        = in_rd;
            mem_valid_next_s = 1'b1;
            mem_addr_next_s  = {in_mem_addr[31:2], 2'b00};
            mem_wdata_next_s = store_data(op_s, in_mem_data);
            mem_wstrb_next_s = store_strb(op_s, in_mem_addr[1:0]);
          end
        end else if (out_valid_r && out_ready) begin
          out_valid_next_s = 1'b0;
        end else begin
          out_valid_next_s = out_valid_r;
        end
      end
      ST_BUS: begin
        if (mem_ready) begin
          mem_valid_next_s   = 1'b0;
          out_valid_next_s   = 1'b1;
          out_mis_next_s     = 1'b0;
          out_rd_next_s      = (op_r <= OP_LBU) ? rd_r : 5'd0;
          out_rd_data_next_s = (op_r <= OP_LBU) ? load_value(op_r, mem_rdata, off_r)
                                                : 32'h0000_0000;
        end else begin
          mem_valid_next_s = mem_valid_r;
        end
      end
      default: begin
        mem_valid_next_s = 1'b0;
      end
    endcase
  end

  assign in_ready       = in_ready_s;
  assign mem_valid      = mem_valid_r;
  assign mem_addr       = mem_addr_r;
  assign mem_wdata      = mem_wdata_r;
  assign mem_wstrb      = mem_wstrb_r;
  assign out_valid      = out_valid_r;
  assign out_rd         = out_rd_r;
  assign out_rd_data    = out_rd_data_r;
  assign out_misaligned = out_mis_r;

endmodule

// File: tb/tb_memory_accessor.sv
// Directed testbench for memory_accessor: hand-computed expectations checked
// with immediate assertions one cycle step at a time.
module tb_memory_accessor;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_rd_data;
  logic [31:0] in_mem_addr;
  logic [31:0] in_mem_data;
  logic        in_is_lb, in_is_lbu, in_is_lh, in_is_lhu, in_is_lw;
  logic        in_is_sb, in_is_sh, in_is_sw;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_rd_data;
  logic        out_misaligned;

  int tests = 0;
  int fails = 0;

  memory_accessor dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rd_data(in_rd_data),
    .in_mem_addr(in_mem_addr), .in_mem_data(in_mem_data),
    .in_is_lb(in_is_lb), .in_is_lbu(in_is_lbu), .in_is_lh(in_is_lh),
    .in_is_lhu(in_is_lhu), .in_is_lw(in_is_lw),
    .in_is_sb(in_is_sb), .in_is_sh(in_is_sh), .in_is_sw(in_is_sw),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_rd_data(out_rd_data), .out_misaligned(out_misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = 1'b0; in_rd = 5'd0; in_rd_data = 32'h0; in_mem_addr = 32'h0;
    in_mem_data = 32'h0;
    in_is_lb = 1'b0; in_is_lbu = 1'b0; in_is_lh = 1'b0; in_is_lhu = 1'b0;
    in_is_lw = 1'b0; in_is_sb = 1'b0; in_is_sh = 1'b0; in_is_sw = 1'b0;
  endtask

  initial begin
    clear_in();
    reset = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h0; out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_mem_valid", mem_valid, 32'd0);
    chk("rst_in_ready", in_ready, 32'd1);
    chk("rst_out_rd", out_rd, 32'd0);
    chk("rst_out_rd_data", out_rd_data, 32'h0);
    chk("rst_misaligned", out_misaligned, 32'd0);
    chk("rst_wstrb", mem_wstrb, 32'd0);

    // ALU pass-through, latency 1.
    in_valid = 1'b1; in_rd = 5'd5; in_rd_data = 32'h0000_1234;
    step();
    in_rd = 5'd1; in_rd_data = 32'h0000_0011;
    chk("alu_valid", out_valid, 32'd1);
    chk("alu_rd", out_rd, 32'd5);
    chk("alu_data", out_rd_data, 32'h0000_1234);
    chk("alu_in_ready", in_ready, 32'd1);
    // Back-to-back results, no bubble.
    step();
    in_rd = 5'd2; in_rd_data = 32'h0000_0022;
    chk("b2b1_rd", out_rd, 32'd1);
    chk("b2b1_data", out_rd_data, 32'h0000_0011);
    step();
    clear_in();
    chk("b2b2_valid", out_valid, 32'd1);
    chk("b2b2_rd", out_rd, 32'd2);
    step();
    chk("alu_drop", out_valid, 32'd0);

    // lb from 0x1003, mem_ready in the first bus cycle.
    in_valid = 1'b1; in_is_lb = 1'b1; in_mem_addr = 32'h0000_1003; in_rd = 5'd7;
    step();
    clear_in();
    chk("lb_mem_valid", mem_valid, 32'd1);
    chk("lb_mem_addr", mem_addr, 32'h0000_1000);
    chk("lb_wstrb", mem_wstrb, 32'd0);
    chk("lb_in_ready", in_ready, 32'd0);
    chk("lb_out_valid0", out_valid, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h8011_2233;
    step();
    mem_ready = 1'b0;
    chk("lb_mem_drop", mem_valid, 32'd0);
    chk("lb_out_valid", out_valid, 32'd1);
    chk("lb_out_rd", out_rd, 32'd7);
    chk("lb_out_data", out_rd_data, 32'hFFFF_FF80);
    step();

    // sh to 0x102.
    in_valid = 1'b1; in_is_sh = 1'b1; in_mem_addr = 32'h0000_0102;
    in_mem_data = 32'hABCD_1234; in_rd = 5'd9;
    step();
    clear_in();
    chk("sh_wdata", mem_wdata, 32'h1234_1234);
    chk("sh_wstrb", mem_wstrb, 32'h0000_000C);
    chk("sh_addr", mem_addr, 32'h0000_0100);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("sh_out_valid", out_valid, 32'd1);
    chk("sh_out_rd", out_rd, 32'd0);
    step();

    // sb to 0x5.
    in_valid = 1'b1; in_is_sb = 1'b1; in_mem_addr = 32'h0000_0005;
    in_mem_data = 32'hFFFF_FFA5;
    step();
    clear_in();
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_wstrb", mem_wstrb, 32'h0000_0002);
    chk("sb_addr", mem_addr, 32'h0000_0004);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();

    // Misaligned lw at 0x101: no bus cycle.
    in_valid = 1'b1; in_is_lw = 1'b1; in_mem_addr = 32'h0000_0101; in_rd = 5'd3;
    step();
    clear_in();
    chk("mis_mem_valid", mem_valid, 32'd0);
    chk("mis_out_valid", out_valid, 32'd1);
    chk("mis_flag", out_misaligned, 32'd1);
    chk("mis_rd", out_rd, 32'd0);
    chk("mis_data", out_rd_data, 32'h0);
    step();
    chk("mis_drop", out_valid, 32'd0);

    // lhu at 0x2 with mem_ready held off for 3 cycles.
    in_valid = 1'b1; in_is_lhu = 1'b1; in_mem_addr = 32'h0000_0002; in_rd = 5'd4;
    step();
    clear_in();
    for (int i = 0; i < 3; i++) begin
      chk("lhu_hold_valid", mem_valid, 32'd1);
      chk("lhu_hold_addr", mem_addr, 32'h0);
      chk("lhu_hold_wstrb", mem_wstrb, 32'd0);
      chk("lhu_hold_inrdy", in_ready, 32'd0);
      step();
    end
    chk("lhu_still_valid", mem_valid, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h8001_5555;
    step();
    mem_ready = 1'b0;
    chk("lhu_out_valid", out_valid, 32'd1);
    chk("lhu_out_rd", out_rd, 32'd4);
    chk("lhu_out_data", out_rd_data, 32'h0000_8001);
    step();

    // Priority: lw beats sb, so this is a read of the full word.
    in_valid = 1'b1; in_is_lw = 1'b1; in_is_sb = 1'b1; in_mem_addr = 32'h0000_0200;
    in_rd = 5'd12; in_mem_data = 32'h0000_00EE;
    step();
    clear_in();
    chk("prio_wstrb", mem_wstrb, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ready = 1'b0;
    chk("prio_data", out_rd_data, 32'hDEAD_BEEF);
    chk("prio_rd", out_rd, 32'd12);
    step();

    // Reset during BUS discards the pending load.
    in_valid = 1'b1; in_is_lw = 1'b1; in_mem_addr = 32'h0000_0010; in_rd = 5'd6;
    step();
    clear_in();
    chk("rbus_mem_valid", mem_valid, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rbus_mem_drop", mem_valid, 32'd0);
    chk("rbus_out_valid", out_valid, 32'd0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("rbus_no_emit", out_valid, 32'd0);

    // Output hold under back-pressure.
    out_ready = 1'b0;
    in_valid = 1'b1; in_rd = 5'd10; in_rd_data = 32'h0000_CAFE;
    step();
    in_rd = 5'd11; in_rd_data = 32'h0000_BEEF;
    chk("hold_valid", out_valid, 32'd1);
    chk("hold_in_ready", in_ready, 32'd0);
    step();
    chk("hold_rd", out_rd, 32'd10);
    chk("hold_data", out_rd_data, 32'h0000_CAFE);
    chk("hold_valid2", out_valid, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("hold_release_rdy", in_ready, 32'd1);
    step();
    clear_in();
    chk("hold_next_rd", out_rd, 32'd11);
    chk("hold_next_data", out_rd_data, 32'h0000_BEEF);
    step();
    chk("hold_drop", out_valid, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
